ahb_rr_arbiter: RTL and testbench

Two-manager AHB-Lite arbiter and bus controller that shares the single AES subordinate between requesters, for example a CPU port and a DMA/key-loader port.
- Grants the address phase round-robin.
- Muxes address/control and write data to the subordinate.
- Tracks data-phase ownership so that hrdata/hresp/hready return only to the manager that issued the transfer.
- Sits between the managers and the AES AHB subordinate; the subordinate-side signals match the team's ahb_if.

---
 rtl/ahb_arb_pkg.sv | 45 ++++
 rtl/ahb_rr_arbiter_if.sv | 46 ++++
 rtl/ahb_rr_pick.sv | 20 ++
 rtl/ahb_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and the round-robin search helper for the manager arbiter.
// Pure declarations; no state, no timing.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int MAX_NREQ = 8;
    localparam int PTR_W    = 3;

    // First set bit of req strictly after ptr (wrapping), ptr itself last; ptr if req is empty.
    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                                 input logic [MAX_NREQ-1:0] req,
                                                 input int n);
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] idx;
        sel = ptr;
        for (int k = MAX_NREQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = PTR_W'((int'(ptr) + k) % n);
                if (req[idx]) begin
                    sel = idx;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter_if.sv
// Manager-side and subordinate-side signals of the shared AHB segment.
// slave = arbiter view; master = managers plus subordinate (environment) view.
interface ahb_rr_arbiter_if #(
    parameter int NREQ = 2
);
    import ahb_arb_pkg::*;

    logic [NREQ-1:0]       m_hbusreq;
    logic [NREQ-1:0]       m_hgrant;
    logic [NREQ-1:0][31:0] m_haddr;
    logic [NREQ-1:0][1:0]  m_htrans;
    logic [NREQ-1:0]       m_hwrite;
    logic [NREQ-1:0][2:0]  m_hsize;
    logic [NREQ-1:0][2:0]  m_hburst;
    logic [NREQ-1:0][31:0] m_hwdata;
    logic [NREQ-1:0]       m_hready;
    logic [31:0]           m_hrdata;
    logic [NREQ-1:0]       m_hresp;

    logic                  hsel;
    logic [31:0]           haddr;
    htrans_e               htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [31:0]           hwdata;
    logic                  hready;
    logic                  hreadyOut;
    logic [31:0]           hrdata;
    logic                  hresp;

    modport slave (
        input  m_hbusreq, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
        input  hreadyOut, hrdata, hresp,
        output m_hgrant, m_hready, m_hrdata, m_hresp,
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready
    );

    modport master (
        output m_hbusreq, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
        output hreadyOut, hrdata, hresp,
        input  m_hgrant, m_hready, m_hrdata, m_hresp,
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready
    );

endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin selector: nearest requester after ptr_i, ptr_i itself last.
// Latency: zero cycles; no backpressure.
module ahb_rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [NREQ-1:0]  req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    always_comb begin
        idx_o = IDX_W'(rr_next(PTR_W'(ptr_i), MAX_NREQ'(req_i), NREQ));
        vld_o = |req_i;
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB-Lite arbiter sharing one subordinate between NREQ managers, with data-phase routing.
// Latency: grant one cycle after request on an idle bus; hreadyOut=0 freezes grant, owners and muxes.
module ahb_rr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic             hclk,
    input  logic             hrst,
    ahb_rr_arbiter_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [IDX_W-1:0] addr_owner_q, addr_owner_d;
    logic [IDX_W-1:0] data_owner_q, data_owner_d;
    logic             data_valid_q, data_valid_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             parked_q, parked_d;

    logic [NREQ-1:0]  owner_oh;
    logic [NREQ-1:0]  data_oh;
    logic [NREQ-1:0]  pick_req;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             own_req;
    logic             others_req;
    logic             beat;
    logic             locked;
    logic             keep;
    logic [CNT_W-1:0] hold_inc;
    htrans_e          eff_trans;

    always_comb begin
        owner_oh   = NREQ'(1) << addr_owner_q;
        data_oh    = NREQ'(1) << data_owner_q;
        own_req    = bus.m_hbusreq[addr_owner_q];
        others_req = |(bus.m_hbusreq & ~owner_oh);
        eff_trans  = own_req ? htrans_e'(bus.m_htrans[addr_owner_q]) : HTRANS_IDLE;
    end

    always_comb begin
        bus.m_hgrant = owner_oh;
        bus.haddr    = bus.m_haddr[addr_owner_q];
        bus.htrans   = eff_trans;
        bus.hsel     = eff_trans[1];
        bus.hwrite   = bus.m_hwrite[addr_owner_q];
        bus.hsize    = bus.m_hsize[addr_owner_q];
        bus.hburst   = bus.m_hburst[addr_owner_q];
        bus.hwdata   = bus.m_hwdata[data_owner_q];
        bus.hready   = bus.hreadyOut;
        bus.m_hrdata = bus.hrdata;
        // The address owner stalls with the data owner: its address phase is not accepted either.
        bus.m_hready = ~((owner_oh | data_oh) & {NREQ{~bus.hreadyOut}});
        bus.m_hresp  = data_valid_q ? (data_oh & {NREQ{bus.hresp}}) : '0;
    end

    // A parked grant carries no ownership, so a waking bus arbitrates fresh from the pointer.
    assign pick_req = parked_q ? bus.m_hbusreq : (bus.m_hbusreq & ~owner_oh);

    ahb_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .ptr_i (addr_owner_q),
        .req_i (pick_req),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    always_comb begin
        beat     = (eff_trans == HTRANS_NONSEQ) || (eff_trans == HTRANS_SEQ);
        locked   = (eff_trans == HTRANS_SEQ) || (eff_trans == HTRANS_BUSY);
        hold_inc = (beat && (hold_cnt_q < CNT_W'(MAX_HOLD))) ? hold_cnt_q + CNT_W'(1) : hold_cnt_q;
        // hold_inc already counts the beat being accepted now, so the owner gets exactly MAX_HOLD beats.
        keep     = locked || (!parked_q && own_req && ((hold_inc < CNT_W'(MAX_HOLD)) || !others_req));

        addr_owner_d = addr_owner_q;
        data_owner_d = data_owner_q;
        data_valid_d = data_valid_q;
        hold_cnt_d   = hold_cnt_q;
        parked_d     = parked_q;

        if (bus.hreadyOut) begin
            data_owner_d = addr_owner_q;
            data_valid_d = eff_trans[1];
            hold_cnt_d   = hold_inc;
            if (!keep) begin
                if (pick_vld) begin
                    addr_owner_d = pick_idx;
                    parked_d     = 1'b0;
                    if (pick_idx != addr_owner_q) begin
                        hold_cnt_d = '0;
                    end
                end else begin
                    parked_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            addr_owner_q <= '0;
            data_owner_q <= '0;
            data_valid_q <= 1'b0;
            hold_cnt_q   <= '0;
            parked_q     <= 1'b1;
        end else begin
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            data_valid_q <= data_valid_d;
            hold_cnt_q   <= hold_cnt_d;
            parked_q     <= parked_d;
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for the two-manager AHB arbiter; expected values queued at drive time, checked after settle.
module tb_ahb_rr_arbiter;
    import ahb_arb_pkg::*;

    logic hclk = 1'b0;
    logic hrst;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    ahb_rr_arbiter_if #(.NREQ(2)) bus ();

    ahb_rr_arbiter #(
        .NREQ     (2),
        .MAX_HOLD (8)
    ) dut (
        .hclk (hclk),
        .hrst (hrst),
        .bus  (bus.slave)
    );

    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive_idle();
        bus.m_hbusreq = '0;
        bus.m_haddr   = '0;
        bus.m_htrans  = '0;
        bus.m_hwrite  = '0;
        bus.m_hsize   = '0;
        bus.m_hburst  = '0;
        bus.m_hwdata  = '0;
        bus.hreadyOut = 1'b1;
        bus.hrdata    = '0;
        bus.hresp     = HRESP_OKAY;
    endtask

    task automatic mgr(input logic m, input htrans_e tr, input logic [31:0] a,
                       input logic w, input logic [2:0] b);
        bus.m_htrans[m] = tr;
        bus.m_haddr[m]  = a;
        bus.m_hwrite[m] = w;
        bus.m_hburst[m] = b;
        bus.m_hsize[m]  = 3'd2;
    endtask

    initial begin
        hrst = 1'b1;
        drive_idle();
        tick();
        tick();

        expect_v("rst_grant", 32'h1);
        expect_v("rst_htrans", 32'h0);
        expect_v("rst_hsel", 32'h0);
        expect_v("rst_m_hready", 32'h3);
        expect_v("rst_m_hresp", 32'h0);
        settle();
        check(32'(bus.m_hgrant));
        check(32'(bus.htrans));
        check(32'(bus.hsel));
        check(32'(bus.m_hready));
        check(32'(bus.m_hresp));
        hrst = 1'b0;

        // Single write from mgr0 alone
        bus.m_hbusreq = 2'b01;
        tick();
        mgr(1'b0, HTRANS_NONSEQ, 32'h10, 1'b1, HBURST_SINGLE);
        expect_v("t1_grant", 32'h1);
        expect_v("t1_haddr", 32'h10);
        expect_v("t1_hsel", 32'h1);
        expect_v("t1_hwrite", 32'h1);
        settle();
        check(32'(bus.m_hgrant));
        check(bus.haddr);
        check(32'(bus.hsel));
        check(32'(bus.hwrite));
        tick();
        mgr(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
        bus.m_hbusreq  = 2'b00;
        bus.m_hwdata[0] = 32'hA5A5_A5A5;
        bus.hreadyOut  = 1'b0;
        expect_v("t1_hwdata", 32'hA5A5_A5A5);
        expect_v("t1_m_hready_wait", 32'h2);
        settle();
        check(bus.hwdata);
        check(32'(bus.m_hready));
        bus.hreadyOut = 1'b1;
        expect_v("t1_m_hready_go", 32'h3);
        #1;
        check(32'(bus.m_hready));
        tick();

        // Simultaneous requests out of reset: mgr1 first
        hrst = 1'b1;
        drive_idle();
        tick();
        hrst = 1'b0;
        bus.m_hbusreq = 2'b11;
        tick();
        expect_v("t2_grant_first", 32'h2);
        settle();
        check(32'(bus.m_hgrant));
        bus.m_hbusreq = 2'b01;
        bus.hreadyOut = 1'b0;
        tick();
        expect_v("t2_grant_held_in_wait", 32'h2);
        settle();
        check(32'(bus.m_hgrant));
        bus.hreadyOut = 1'b1;
        tick();
        expect_v("t2_grant_handover", 32'h1);
        settle();
        check(32'(bus.m_hgrant));

        // INCR4 from mgr0 with mgr1 requesting: burst is never split
        bus.m_hbusreq = 2'b11;
        for (int b = 0; b < 4; b++) begin
            mgr(1'b0, (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h20 + 32'(4 * b), 1'b0, HBURST_INCR4);
            expect_v($sformatf("t3_grant_b%0d", b), 32'h1);
            expect_v($sformatf("t3_haddr_b%0d", b), 32'h20 + 32'(4 * b));
            expect_v($sformatf("t3_htrans_b%0d", b), (b == 0) ? 32'h2 : 32'h3);
            settle();
            check(32'(bus.m_hgrant));
            check(bus.haddr);
            check(32'(bus.htrans));
            tick();
        end
        mgr(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
        bus.m_hbusreq = 2'b10;
        expect_v("t3_grant_after_burst", 32'h1);
        settle();
        check(32'(bus.m_hgrant));
        tick();

        // mgr1 read with two wait states
        mgr(1'b1, HTRANS_NONSEQ, 32'h40, 1'b0, HBURST_SINGLE);
        expect_v("t4_grant", 32'h2);
        expect_v("t4_haddr", 32'h40);
        expect_v("t4_hsel", 32'h1);
        settle();
        check(32'(bus.m_hgrant));
        check(bus.haddr);
        check(32'(bus.hsel));
        tick();
        mgr(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
        bus.m_hbusreq = 2'b01;
        bus.hreadyOut = 1'b0;
        for (int w = 0; w < 2; w++) begin
            expect_v($sformatf("t4_grant_wait%0d", w), 32'h2);
            expect_v($sformatf("t4_m_hready_wait%0d", w), 32'h1);
            settle();
            check(32'(bus.m_hgrant));
            check(32'(bus.m_hready));
            tick();
        end
        bus.hreadyOut = 1'b1;
        bus.hrdata    = 32'hDEAD_BEEF;
        expect_v("t4_m_hrdata", 32'hDEAD_BEEF);
        expect_v("t4_m_hready_done", 32'h3);
        expect_v("t4_m_hresp", 32'h0);
        settle();
        check(bus.m_hrdata);
        check(32'(bus.m_hready));
        check(32'(bus.m_hresp));
        tick();
        bus.hrdata = 32'h0;

        // Nine singles from mgr0 with mgr1 waiting: handover after the eighth
        bus.m_hbusreq = 2'b11;
        for (int b = 0; b < 8; b++) begin
            mgr(1'b0, HTRANS_NONSEQ, 32'h100 + 32'(4 * b), 1'b0, HBURST_SINGLE);
            expect_v($sformatf("t5_grant_b%0d", b), 32'h1);
            expect_v($sformatf("t5_haddr_b%0d", b), 32'h100 + 32'(4 * b));
            settle();
            check(32'(bus.m_hgrant));
            check(bus.haddr);
            tick();
        end
        mgr(1'b0, HTRANS_NONSEQ, 32'h120, 1'b0, HBURST_SINGLE);
        mgr(1'b1, HTRANS_NONSEQ, 32'h80, 1'b0, HBURST_SINGLE);
        expect_v("t5_grant_forced", 32'h2);
        expect_v("t5_haddr_mgr1", 32'h80);
        settle();
        check(32'(bus.m_hgrant));
        check(bus.haddr);
        tick();
        mgr(1'b1, HTRANS_NONSEQ, 32'h84, 1'b0, HBURST_SINGLE);
        expect_v("t5_grant_hold_reset", 32'h2);
        expect_v("t5_haddr_mgr1_b2", 32'h84);
        settle();
        check(32'(bus.m_hgrant));
        check(bus.haddr);
        tick();

        // ERROR response on a mgr1 write
        mgr(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
        bus.m_hbusreq = 2'b10;
        mgr(1'b1, HTRANS_NONSEQ, 32'h200, 1'b1, HBURST_SINGLE);
        expect_v("t6_grant", 32'h2);
        expect_v("t6_haddr", 32'h200);
        expect_v("t6_hwrite", 32'h1);
        settle();
        check(32'(bus.m_hgrant));
        check(bus.haddr);
        check(32'(bus.hwrite));
        tick();
        mgr(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
        bus.m_hwdata[1] = 32'h1234_5678;
        bus.hreadyOut   = 1'b0;
        bus.hresp       = HRESP_ERROR;
        expect_v("t6_m_hresp_err1", 32'h2);
        expect_v("t6_m_hready_err1", 32'h1);
        expect_v("t6_hwdata", 32'h1234_5678);
        settle();
        check(32'(bus.m_hresp));
        check(32'(bus.m_hready));
        check(bus.hwdata);
        tick();
        bus.hreadyOut = 1'b1;
        expect_v("t6_m_hresp_err2", 32'h2);
        expect_v("t6_m_hready_err2", 32'h3);
        settle();
        check(32'(bus.m_hresp));
        check(32'(bus.m_hready));
        tick();
        bus.hresp = HRESP_OKAY;
        mgr(1'b1, HTRANS_NONSEQ, 32'h300, 1'b1, HBURST_INCR4);
        expect_v("t6_m_hresp_clear", 32'h0);
        expect_v("t6_htrans_burst", 32'h2);
        settle();
        check(32'(bus.m_hresp));
        check(32'(bus.htrans));
        tick();

        // Reset in the middle of the burst
        mgr(1'b1, HTRANS_SEQ, 32'h304, 1'b1, HBURST_INCR4);
        expect_v("t7_htrans_seq", 32'h3);
        expect_v("t7_haddr_seq", 32'h304);
        settle();
        check(32'(bus.htrans));
        check(bus.haddr);
        hrst = 1'b1;
        tick();
        hrst = 1'b0;
        expect_v("t7_htrans_after_rst", 32'h0);
        expect_v("t7_hsel_after_rst", 32'h0);
        expect_v("t7_grant_after_rst", 32'h1);
        expect_v("t7_m_hready_after_rst", 32'h3);
        settle();
        check(32'(bus.htrans));
        check(32'(bus.hsel));
        check(32'(bus.m_hgrant));
        check(32'(bus.m_hready));

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_drained observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
